// File: rtl/value_limit_arbiter.sv
// Round-robin arbiter that shares one registered 16->10 bit saturating limiter
// between NCH requesters and keeps per-channel clip statistics.
module value_limit_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      req,
    input  logic [16*NCH-1:0]   value,
    input  logic                clear_stats,
    output logic [NCH-1:0]      ack,
    output logic                out_valid,
    output logic [CHW-1:0]      out_chan,
    output logic signed [9:0]   out_data,
    output logic                out_clipped,
    output logic [NCH-1:0]      clip_sticky,
    output logic [16*NCH-1:0]   clip_count
);

    localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

    logic [CHW-1:0]         rr_ptr_r;
    logic [NCH-1:0]         inflight_r;
    logic [NCH-1:0]         eligible_s;
    logic                   grant_valid_s;
    logic [CHW-1:0]         grant_chan_s;
    logic [CHW-1:0]         cand_s;
    logic [NCH-1:0]         grant_onehot_s;
    logic signed [15:0]     value_arr_s [NCH];
    logic signed [15:0]     issue_value_s;
    logic [10:0]            limit_s;
    logic [NCH-1:0][15:0]   clip_cnt_r;
    logic [NCH-1:0]         clip_sticky_r;

    // Channel index base+off, wrapping at NCH (NCH need not be a power of two)
    function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] base,
                                                input logic [CHW-1:0] off);
        logic [CHW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum >= NCH_W) ? CHW'(sum - NCH_W) : sum[CHW-1:0];
    endfunction

    // Returns {clipped, limited value}
    function automatic logic [10:0] limit_fn(input logic signed [15:0] v);
        logic [10:0] r;
        if (v > 16'sd511) begin
            r = {1'b1, 10'h1FF};
        end else if (v < -16'sd512) begin
            r = {1'b1, 10'h200};
        end else begin
            r = {1'b0, v[9:0]};
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Unpack the flat per-channel value bus
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            value_arr_s[k] = value[16*k +: 16];
        end
    end

    // Round-robin search: scanned from the far end so the smallest offset from rr_ptr_r wins
    always_comb begin
        eligible_s    = req & ~inflight_r;
        grant_valid_s = 1'b0;
        grant_chan_s  = '0;
        cand_s        = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand_s        = wrap_add(rr_ptr_r, CHW'(i));
            grant_chan_s  = eligible_s[cand_s] ? cand_s : grant_chan_s;
            grant_valid_s = grant_valid_s | eligible_s[cand_s];
        end
    end

    // Issue stage: one-hot grant and value mux into the limiter
    always_comb begin
        grant_onehot_s               = '0;
        grant_onehot_s[grant_chan_s] = grant_valid_s;
        issue_value_s                = value_arr_s[grant_chan_s];
        limit_s                      = limit_fn(issue_value_s);
    end

    // Result stage, round-robin pointer and in-flight tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r    <= '0;
            inflight_r  <= '0;
            ack         <= '0;
            out_valid   <= 1'b0;
            out_chan    <= '0;
            out_data    <= '0;
            out_clipped <= 1'b0;
        end else begin
            // A granted channel is blocked exactly through its ack cycle
            inflight_r  <= grant_onehot_s;
            ack         <= grant_onehot_s;
            out_valid   <= grant_valid_s;
            out_chan    <= grant_chan_s;
            out_data    <= grant_valid_s ? limit_s[9:0] : 10'h000;
            out_clipped <= grant_valid_s & limit_s[10];
            rr_ptr_r    <= grant_valid_s ? wrap_add(grant_chan_s, CHW'(1)) : rr_ptr_r;
        end
    end

    // Clip statistics; a clear in the same cycle as a clip event wins
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_cnt_r    <= '0;
            clip_sticky_r <= '0;
        end else if (clear_stats) begin
            clip_cnt_r    <= '0;
            clip_sticky_r <= '0;
        end else if (out_valid && out_clipped) begin
            clip_cnt_r[out_chan]    <= sat_inc(clip_cnt_r[out_chan]);
            clip_sticky_r[out_chan] <= 1'b1;
        end
    end

    assign clip_count  = clip_cnt_r;
    assign clip_sticky = clip_sticky_r;

endmodule

// File: tb/tb_value_limit_arbiter.sv
// Scoreboard bench: a request-level model predicts each result, a separate
// monitor compares DUT outputs and statistics against it every cycle.
module tb_value_limit_arbiter;

    localparam int NCH = 4;
    localparam int CHW = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH-1:0]      req = '0;
    logic [16*NCH-1:0]   value = '0;
    logic                clear_stats = 1'b0;
    logic [NCH-1:0]      ack;
    logic                out_valid;
    logic [CHW-1:0]      out_chan;
    logic signed [9:0]   out_data;
    logic                out_clipped;
    logic [NCH-1:0]      clip_sticky;
    logic [16*NCH-1:0]   clip_count;

    always #5 clk = ~clk;

    value_limit_arbiter #(.NCH(NCH), .CHW(CHW)) dut (
        .clk(clk), .rst(rst), .req(req), .value(value), .clear_stats(clear_stats),
        .ack(ack), .out_valid(out_valid), .out_chan(out_chan), .out_data(out_data),
        .out_clipped(out_clipped), .clip_sticky(clip_sticky), .clip_count(clip_count)
    );

    typedef struct { int chan; int data; bit clip; } exp_t;

    exp_t sb_q [$];
    int   vq [NCH][$];      // pending request values per channel (front = presented)
    int   m_ptr = 0;
    int   m_prev = -1;      // channel granted in the previous cycle
    bit   m_prev_clip = 1'b0;
    int   exp_cnt [NCH];
    bit   exp_sticky [NCH];
    bit   exp_zero_out = 1'b0;
    int   ack_cnt [NCH];
    bit   mon_en = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    function automatic int limit(input int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    function automatic int rnd_val();
        logic signed [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 5))
            0: return 511;
            1: return 512;
            2: return -512;
            3: return -513;
            4: return int'(r);
            default: return int'($urandom_range(0, 1023)) - 512;
        endcase
    endfunction

    // One clock cycle: retire acked requests, drive inputs, advance the reference model
    task automatic cycle(input bit do_rst, input bit do_clr);
        int last;
        int g;
        int c;
        @(negedge clk);
        last = m_prev;
        if (last >= 0 && vq[last].size() > 0) void'(vq[last].pop_front());
        for (int k = 0; k < NCH; k++) begin
            if (vq[k].size() > 0) begin
                req[k] = 1'b1;
                value[16*k +: 16] = 16'(vq[k][0]);
            end else begin
                req[k] = 1'b0;
                value[16*k +: 16] = 16'($urandom);
            end
        end
        rst = do_rst;
        clear_stats = do_clr;
        // statistics after this edge: the result shown now is last cycle's grant
        if (do_rst || do_clr) begin
            for (int k = 0; k < NCH; k++) begin
                exp_cnt[k] = 0;
                exp_sticky[k] = 1'b0;
            end
        end else if (last >= 0 && m_prev_clip) begin
            exp_sticky[last] = 1'b1;
            if (exp_cnt[last] < 65535) exp_cnt[last]++;
        end
        exp_zero_out = do_rst;
        m_prev = -1;
        m_prev_clip = 1'b0;
        if (do_rst) begin
            m_ptr = 0;
        end else begin
            g = -1;
            for (int i = 0; i < NCH; i++) begin
                c = (m_ptr + i) % NCH;
                if (g < 0 && req[c] && c != last) g = c;
            end
            if (g >= 0) begin
                sb_q.push_back('{chan: g, data: limit(vq[g][0]), clip: (limit(vq[g][0]) != vq[g][0])});
                m_prev = g;
                m_prev_clip = (limit(vq[g][0]) != vq[g][0]);
                m_ptr = (g + 1) % NCH;
            end
        end
    endtask

    // Monitor: compares every cycle, one edge after the model predicted it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                for (int k = 0; k < NCH; k++) if (ack[k]) ack_cnt[k]++;
                if (exp_zero_out) begin
                    chk("rst_out_data", {22'd0, out_data}, 32'd0);
                    chk("rst_out_chan", {30'd0, out_chan}, 32'd0);
                    chk("rst_out_clipped", {31'd0, out_clipped}, 32'd0);
                end
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("out_valid", {31'd0, out_valid}, 32'd1);
                    chk("out_chan", {30'd0, out_chan}, e.chan);
                    chk("out_data", {22'd0, out_data}, e.data & 32'h3FF);
                    chk("out_clipped", {31'd0, out_clipped}, {31'd0, e.clip});
                    chk("ack", {28'd0, ack}, 32'd1 << e.chan);
                end else begin
                    chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
                    chk("ack_idle", {28'd0, ack}, 32'd0);
                end
                for (int k = 0; k < NCH; k++) begin
                    chk($sformatf("clip_count[%0d]", k), {16'd0, clip_count[16*k +: 16]}, exp_cnt[k]);
                    chk($sformatf("clip_sticky[%0d]", k), {31'd0, clip_sticky[k]}, {31'd0, exp_sticky[k]});
                end
            end
        end
    end

    initial begin
        int a;
        for (int k = 0; k < NCH; k++) begin
            exp_cnt[k] = 0;
            exp_sticky[k] = 1'b0;
            ack_cnt[k] = 0;
        end
        cycle(1'b1, 1'b0);
        mon_en = 1'b1;
        cycle(1'b1, 1'b0);

        // all channels request continuously from reset: 0,1,2,3,0,... one result per cycle
        for (int k = 0; k < NCH; k++) for (int j = 0; j < 6; j++) vq[k].push_back(rnd_val());
        repeat (30) cycle(1'b0, 1'b0);

        // single channel 0, in-range value
        vq[0].push_back(255);
        repeat (4) cycle(1'b0, 1'b0);

        // channel 1 clips high then low
        cycle(1'b0, 1'b1);
        vq[1].push_back(1000);
        vq[1].push_back(-1000);
        repeat (7) cycle(1'b0, 1'b0);
        chk("t2_clip_count1", {16'd0, clip_count[16 +: 16]}, 32'd2);
        chk("t2_clip_sticky1", {31'd0, clip_sticky[1]}, 32'd1);

        // channel 2 holds req for 6 cycles: three acks
        a = ack_cnt[2];
        for (int j = 0; j < 20; j++) vq[2].push_back(-300 + j);
        repeat (6) cycle(1'b0, 1'b0);
        vq[2].delete();
        repeat (3) cycle(1'b0, 1'b0);
        chk("t4_ack_count2", ack_cnt[2] - a, 32'd3);

        // clip result coinciding with clear_stats is not counted
        vq[3].push_back(3000);
        repeat (4) cycle(1'b0, 1'b0);
        vq[3].push_back(-4000);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("t5_clip_count3", {16'd0, clip_count[48 +: 16]}, 32'd0);
        chk("t5_clip_sticky3", {31'd0, clip_sticky[3]}, 32'd0);

        // counter saturation from a preloaded value
        cycle(1'b0, 1'b0);
        dut.clip_cnt_r[1] <= 16'hFFFE;
        exp_cnt[1] = 32'hFFFE;
        vq[1].push_back(600);
        vq[1].push_back(700);
        vq[1].push_back(-900);
        repeat (8) cycle(1'b0, 1'b0);
        chk("sat_clip_count1", {16'd0, clip_count[16 +: 16]}, 32'hFFFF);

        // reset while a grant is being issued
        vq[1].push_back(5000);
        cycle(1'b0, 1'b0);
        vq[2].push_back(100);
        cycle(1'b1, 1'b0);
        vq[0].push_back(-7);
        vq[3].push_back(42);
        cycle(1'b0, 1'b0);
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_ack", {28'd0, ack}, 32'd0);
        chk("t6_stats_lo", clip_count[31:0], 32'd0);
        chk("t6_stats_hi", clip_count[63:32], 32'd0);
        chk("t6_sticky", {28'd0, clip_sticky}, 32'd0);
        cycle(1'b0, 1'b0);
        chk("t6_next_grant_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_next_grant_chan", {30'd0, out_chan}, 32'd0);
        repeat (6) cycle(1'b0, 1'b0);

        // randomized traffic with occasional clears and resets
        repeat (600) begin
            for (int k = 0; k < NCH; k++) begin
                if (vq[k].size() == 0 && $urandom_range(0, 2) != 0) vq[k].push_back(rnd_val());
            end
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0));
        end
        repeat (12) cycle(1'b0, 1'b0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
